alu_cc_unit: RTL

- Consumer side of the ALU result interface: captures ALU `ans`/`overflow` into the Y86 condition-code register (ZF, SF, OF) and a result register.
- Answers registered condition queries (jXX/cmovXX ifun) for the execute stage.
- Sits directly after the 2-bit-control ALU (add/sub/and/xor) in the execute stage.
- Sequential: CC register, result register, registered query response, stall hold, written-since-reset tracking.

---
 rtl/alu_cc_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/alu_cc_unit.sv
// Y86 condition-code register and registered condition-query unit behind the execute-stage ALU.
// Optional macro ALU_CC_BYPASS_EN forwards same-cycle incoming flags into the query evaluation.
module alu_cc_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] alu_ans,
    input  logic             alu_overflow,
    input  logic             alu_valid,
    input  logic             set_cc,
    input  logic             stall,
    input  logic             cond_req,
    input  logic [3:0]       cond_ifun,
    output logic [WIDTH-1:0] result_q,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             cc_written,
    output logic             cnd_valid,
    output logic             cnd,
    output logic             cond_err
);

    logic upd;
    logic acc;
    logic in_zf;
    logic in_sf;
    logic eval_zf;
    logic eval_sf;
    logic eval_of;
    logic eval_cnd;
    logic eval_err;
    logic lt;

    assign upd   = alu_valid & ~stall;
    assign acc   = cond_req & ~stall;
    assign in_zf = (alu_ans == '0);
    assign in_sf = alu_ans[WIDTH-1];

`ifdef ALU_CC_BYPASS_EN
    // Forward flags being written this edge so a same-cycle query sees them.
    always_comb begin
        eval_zf = zf;
        eval_sf = sf;
        eval_of = of;
        if (acc && upd && set_cc) begin
            eval_zf = in_zf;
            eval_sf = in_sf;
            eval_of = alu_overflow;
        end
    end
`else
    always_comb begin
        eval_zf = zf;
        eval_sf = sf;
        eval_of = of;
    end
`endif

    assign lt = eval_sf ^ eval_of;

    always_comb begin
        eval_cnd = 1'b0;
        eval_err = 1'b0;
        case (cond_ifun)
            4'd0:    eval_cnd = 1'b1;
            4'd1:    eval_cnd = lt | eval_zf;
            4'd2:    eval_cnd = lt;
            4'd3:    eval_cnd = eval_zf;
            4'd4:    eval_cnd = ~eval_zf;
            4'd5:    eval_cnd = ~lt;
            4'd6:    eval_cnd = ~lt & ~eval_zf;
            default: eval_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= '0;
            zf         <= 1'b1;
            sf         <= 1'b0;
            of         <= 1'b0;
            cc_written <= 1'b0;
            cnd_valid  <= 1'b0;
            cnd        <= 1'b0;
            cond_err   <= 1'b0;
        end else begin
            cnd_valid <= acc;
            if (upd) begin
                result_q <= alu_ans;
                if (set_cc) begin
                    zf         <= in_zf;
                    sf         <= in_sf;
                    of         <= alu_overflow;
                    cc_written <= 1'b1;
                end
            end
            if (acc) begin
                cnd      <= eval_cnd;
                cond_err <= eval_err;
            end
        end
    end

endmodule
